// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write/reserve
// requests from decode/writeback, and the clear-sweep control/status lines.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 3,
  parameter int NUM_RD     = 2
) ();

  logic [NUM_RD*ADDR_BITS-1:0]  rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_pend;

  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rsv_en;
  logic [ADDR_BITS-1:0]  rsv_addr;

  logic                  clr_req;
  logic                  busy;
  logic                  clr_done;
  logic                  wr_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pend, busy, clr_done, wr_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pend, busy, clr_done, wr_err
  );

endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with r0 hardwired to zero, pending scoreboard
// and a one-register-per-cycle clear sweep. Optional forwarding: REGFILE_BYPASS_EN.
//
// state | meaning
// IDLE  | normal operation, writes/reserves accepted
// SWEEP | zeroing reg[count] and pend[count], count = 1 .. NUM_REGS-1
// DONE  | sweep finished, clr_done high for this cycle
module regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 3,
  parameter int NUM_RD     = 2
) (
  input logic         clk,
  input logic         clear_n,
  regfile_mp_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] CNT_FIRST = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] CNT_LAST  = ADDR_BITS'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  count;
  logic                  clr_done_q;
  logic                  wr_err_q;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pend;

  logic                  wr_ok;
  logic                  rsv_ok;
  logic                  sweep_on;

  assign wr_ok    = bus.wr_en  && (state == IDLE) && (bus.wr_addr  != '0);
  assign rsv_ok   = bus.rsv_en && (state == IDLE) && (bus.rsv_addr != '0);
  assign sweep_on = (state == SWEEP);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      count      <= CNT_FIRST;
      clr_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_err_q   <= bus.wr_en && (state != IDLE);
      clr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state <= SWEEP;
            count <= CNT_FIRST;
          end
        end
        SWEEP: begin
          // Terminal compare holds count at NUM_REGS-1, so it never wraps to r0.
          if (count == CNT_LAST) begin
            state      <= DONE;
            clr_done_q <= 1'b1;
          end else begin
            count <= count + CNT_FIRST;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (sweep_on && (count == ADDR_BITS'(i))) begin
          regs[i] <= '0;
          pend[i] <= 1'b0;
        end else begin
          if (wr_ok && (bus.wr_addr == ADDR_BITS'(i))) begin
            regs[i] <= bus.wr_data;
          end
          // Reserve beats a same-cycle write: the result is still outstanding.
          if (rsv_ok && (bus.rsv_addr == ADDR_BITS'(i))) begin
            pend[i] <= 1'b1;
          end else if (wr_ok && (bus.wr_addr == ADDR_BITS'(i))) begin
            pend[i] <= 1'b0;
          end
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic rsv_same;
  assign rsv_same = rsv_ok && (bus.rsv_addr == bus.wr_addr);
`endif

  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
  logic [NUM_RD-1:0]            rd_pend_c;
  logic [ADDR_BITS-1:0]         ra;

  always_comb begin
    rd_data_c = '0;
    rd_pend_c = '0;
    ra        = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.rd_addr[k*ADDR_BITS +: ADDR_BITS];
      if (ra != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.wr_addr == ra)) begin
          rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
          rd_pend_c[k]                          = rsv_same;
        end else begin
          rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
          rd_pend_c[k]                          = pend[ra];
        end
`else
        rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
        rd_pend_c[k]                          = pend[ra];
`endif
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_pend  = rd_pend_c;
  assign bus.busy     = (state != IDLE);
  assign bus.clr_done = clr_done_q;
  assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_WIDTH 16, ADDR_BITS 3, NUM_RD 2).
module tb_regfile_mp;

  localparam int DW = 16;
  localparam int AB = 3;
  localparam int NR = 2;

  logic clk;
  logic clear_n;
  int   checks;
  int   errors;
  int   busy_cycles;
  int   done_pulses;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_RD(NR)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AB-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [AB-1:0] a1, input logic [AB-1:0] a0);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    clear_n      = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.clr_req  = 1'b0;

    #12;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_clr_done", 32'(bus.clr_done), 32'd0);
    check("reset_wr_err", 32'(bus.wr_err), 32'd0);
    clear_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd(AB'(a), AB'(a));
      check($sformatf("reset_data_r%0d", a), 32'(bus.rd_data), 32'h0);
      check($sformatf("reset_pend_r%0d", a), 32'(bus.rd_pend), 32'h0);
    end

    write(3'd3, 16'hBEEF);
    rd(3'd3, 3'd3);
    check("wr_r3_both_ports", 32'(bus.rd_data), 32'hBEEF_BEEF);
    check("wr_r3_wr_err", 32'(bus.wr_err), 32'd0);

    write(3'd0, 16'h1234);
    rd(3'd0, 3'd3);
    check("wr_r0_discard", 32'(bus.rd_data), 32'h0000_BEEF);
    check("wr_r0_no_err", 32'(bus.wr_err), 32'd0);

    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 3'd5;
    tick();
    bus.rsv_en   = 1'b0;
    rd(3'd5, 3'd5);
    check("rsv_r5_pend", 32'(bus.rd_pend), 32'h3);
    rd(3'd5, 3'd3);
    check("rsv_r5_mixed_pend", 32'(bus.rd_pend), 32'h2);
    rd(3'd5, 3'd0);
    check("rsv_r0_pend", 32'(bus.rd_pend), 32'h2);

    write(3'd5, 16'h00A5);
    rd(3'd5, 3'd5);
    check("wr_r5_pend_clr", 32'(bus.rd_pend), 32'h0);
    check("wr_r5_data", 32'(bus.rd_data), 32'h00A5_00A5);

    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 3'd5;
    write(3'd5, 16'h5A5A);
    bus.rsv_en   = 1'b0;
    rd(3'd5, 3'd5);
    check("rsv_wr_same_pend", 32'(bus.rd_pend), 32'h3);
    check("rsv_wr_same_data", 32'(bus.rd_data), 32'h5A5A_5A5A);

    write(3'd4, 16'h1111);
    bus.rd_addr = {3'd0, 3'd4};
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd4;
    bus.wr_data = 16'h2222;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", 32'(bus.rd_data), 32'h0000_2222);
`else
    check("nobypass_same_cycle", 32'(bus.rd_data), 32'h0000_1111);
`endif
    check("bypass_pend", 32'(bus.rd_pend), 32'h0);
    tick();
    bus.wr_en = 1'b0;
    rd(3'd0, 3'd4);
    check("r4_next_cycle", 32'(bus.rd_data), 32'h0000_2222);

    for (int a = 1; a < 8; a++) begin
      write(AB'(a), 16'h1000 + 16'(a));
    end
    rd(3'd7, 3'd1);
    check("fill_r1_r7", 32'(bus.rd_data), 32'h1007_1001);

    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int n = 0; n < 20 && bus.busy; n++) begin
      busy_cycles++;
      if (bus.clr_done) done_pulses++;
      if (n == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = 16'hDEAD;
      end
      if (n == 4) begin
        check("sweep_wr_err_pulse", 32'(bus.wr_err), 32'd1);
        bus.wr_en = 1'b0;
      end
      if (n == 5) check("sweep_wr_err_drop", 32'(bus.wr_err), 32'd0);
      tick();
    end
    check("sweep_busy_cycles", 32'(busy_cycles), 32'd8);
    check("sweep_done_pulses", 32'(done_pulses), 32'd1);
    check("after_sweep_clr_done", 32'(bus.clr_done), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd(AB'(a), AB'(a));
      check($sformatf("swept_data_r%0d", a), 32'(bus.rd_data), 32'h0);
      check($sformatf("swept_pend_r%0d", a), 32'(bus.rd_pend), 32'h0);
    end

    write(3'd2, 16'hABCD);
    write(3'd7, 16'h7777);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    tick();
    tick();
    rd(3'd7, 3'd0);
    check("mid_sweep_r7_kept", 32'(bus.rd_data), 32'h7777_0000);
    check("mid_sweep_busy", 32'(bus.busy), 32'd1);
    #1;
    clear_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    rd(3'd7, 3'd2);
    check("async_rst_data", 32'(bus.rd_data), 32'h0);
    tick();
    clear_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    write(3'd2, 16'h0202);
    rd(3'd7, 3'd2);
    check("post_rst_write_r2", 32'(bus.rd_data), 32'h0000_0202);
    check("post_rst_wr_err", 32'(bus.wr_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the processor's 16-bit register file: NUM_RD combinational read ports, one synchronous write port, register 0 hardwired to zero.
- Adds an async active-low reset, a per-register pending scoreboard for hazard detection, and a clear-sweep state machine that zeroes the file one register per cycle on request.
- Sits between decode (read/reserve) and writeback (write) in the datapath.

Parameters:
- DATA_WIDTH, 16, width of each register.
- ADDR_BITS, 3, register address width; NUM_REGS = 2**ADDR_BITS (localparam).
- NUM_RD, 2, number of read ports (>=1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_BITS  packed read addresses; port k = bits [k*ADDR_BITS +: ADDR_BITS].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rd_pend  out  NUM_RD  scoreboard pending bit for each read address.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_BITS  write address.
- wr_data  in  DATA_WIDTH  write data.
- rsv_en  in  1  reserve request; marks rsv_addr as pending.
- rsv_addr  in  ADDR_BITS  register to reserve.
- clr_req  in  1  start clear sweep (level, sampled at posedge).
- busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse at sweep completion.
- wr_err  out  1  registered pulse: previous cycle's write was dropped.

Behaviour:
- Reset (clear_n low, async): all registers = 0, pend = 0, state = IDLE, sweep count = 1, busy = 0, clr_done = 0, wr_err = 0. Takes effect immediately, including mid-sweep; the sweep is abandoned.
- Reads are combinational, zero latency. Address 0 always returns 0 and rd_pend = 0.
- rd_pend[k] = pend[rd_addr k], combinational from the scoreboard flops.
- Write: at posedge, if wr_en && state==IDLE && wr_addr!=0, then reg[wr_addr] <= wr_data and pend[wr_addr] <= 0. A write to address 0 is silently discarded (no error).
- Write while state != IDLE: discarded; wr_err = 1 on the following cycle, otherwise wr_err = 0.
- Reserve: at posedge, if rsv_en && state==IDLE && rsv_addr!=0, then pend[rsv_addr] <= 1. Ignored while busy.
- Simultaneous write and reserve to the same address: reserve wins (pend = 1) and data is still written.
- FSM states:
  - IDLE: clr_req=1 -> SWEEP, count = 1.
  - SWEEP: reg[count] <= 0, pend[count] <= 0, count++. When count==NUM_REGS-1, clears it and goes to DONE.
  - DONE: clr_done = 1 for one cycle -> IDLE.
- busy = (state != IDLE), decoded from state flops.
- Sweep timing: lasts NUM_REGS-1 cycles in SWEEP plus 1 in DONE. clr_req while busy is ignored; clr_req still high in IDLE after DONE starts a new sweep.
- Count is ADDR_BITS wide; no wrap is possible because the terminal compare stops it at NUM_REGS-1.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en && state==IDLE && wr_addr!=0 && rd_addr k == wr_addr, then rd_data k = wr_data and rd_pend[k] = 0 in that same cycle, unless the same-cycle reserve targets that address, in which case rd_pend[k] = 1.
- Undefined: reads return the stored (pre-write) value until the next cycle.

Test Plan:
- Reset then read all addresses on both ports -> every rd_data = 0x0000, rd_pend = 0, busy = 0.
- Write 0xBEEF to r3, next cycle read r3 on port 0 and r3 on port 1 -> both 0xBEEF. Write 0x1234 to r0 -> r0 still reads 0, wr_err stays 0.
- Reserve r5 -> rd_pend = 1 for r5. Write 0x00A5 to r5 -> next cycle rd_pend = 0, data 0x00A5. Then reserve and write r5 in the same cycle -> pend = 1, data written.
- Fill r1..r7 with nonzero values, pulse clr_req -> busy for 8 cycles (7 SWEEP + 1 DONE), clr_done pulses once, then all reads are 0. A write issued mid-sweep -> wr_err pulses the next cycle and the value is not stored.
- Drop clear_n asynchronously 3 cycles into a sweep -> all registers 0, busy = 0 immediately. After release, a normal write to r2 works.
- With REGFILE_BYPASS_EN: r4 holds 0x1111, write 0x2222 to r4 while reading r4 -> rd_data = 0x2222 in the same cycle. Without the macro -> 0x1111 that cycle, 0x2222 the next.
